// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared constants and types for the two-port data-memory arbiter.
//   DMEM_DEPTH : number of implemented memory words (addresses >= are errors)
//   DMEM_AW    : address width of requester and memory ports
//   DMEM_DW    : data width
//   state_t    : sequencer states IDLE -> ACCESS -> RESP
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_AW    = 8;
  localparam int DMEM_DW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// Bundles both requester handshakes and the single memory port.
//   req0/1, we0/1, addr0/1, wdata0/1 : requester -> arbiter
//   ack0/1, rdata0/1, err0/1         : arbiter -> requester
//   mem_addr, mem_wdata, mem_read,
//   mem_write                        : arbiter -> memory
//   mem_rdata                        : memory -> arbiter (combinational read)
//   lock0/1                          : requester -> arbiter, only when
//                                      ARB_LOCK_EN is defined
// Modports: slave = arbiter side, master = requesters + memory side.
// -----------------------------------------------------------------------------
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) ();

  logic          req0,   req1;
  logic          we0,    we1;
  logic [AW-1:0] addr0,  addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0,   ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          err0,   err1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic          mem_write;

`ifdef ARB_LOCK_EN
  logic          lock0,  lock1;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
`else
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
`endif

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker, purely combinational.
//   req_i[1:0]   : pending requests
//   last_i       : requester that won the previous grant
//   lock_hold_i  : an active lock restricts the grant to lock_id_i
//   lock_id_i    : locked requester
//   gnt_id_o     : selected requester
//   gnt_valid_o  : a grant is issued this cycle
// A lone request always wins; on a tie the requester that did not win last
// time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_hold_i,
  input  logic       lock_id_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_id_o    = 1'b0;
    gnt_valid_o = 1'b0;
    if (lock_hold_i) begin
      // The locked requester is the only candidate; the other one waits even
      // if the locked one is momentarily idle.
      gnt_id_o    = lock_id_i;
      gnt_valid_o = req_i[lock_id_i];
    end else begin
      unique case (req_i)
        2'b01: begin
          gnt_id_o    = 1'b0;
          gnt_valid_o = 1'b1;
        end
        2'b10: begin
          gnt_id_o    = 1'b1;
          gnt_valid_o = 1'b1;
        end
        2'b11: begin
          gnt_id_o    = ~last_i;
          gnt_valid_o = 1'b1;
        end
        default: begin
          gnt_id_o    = 1'b0;
          gnt_valid_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one 32 x 8 data-memory port between requester 0 (CPU load/store) and
// requester 1 (debug/DMA loader). Each grant performs exactly one access in a
// fixed three-cycle sequence IDLE -> ACCESS -> RESP.
//   CLK   : clock, all state on the rising edge
//   RST_N : asynchronous active-low reset
//   bus   : dmem_arb_if.slave (requester handshakes + memory port)
// Optional feature: define ARB_LOCK_EN to add lock0/lock1, which keep the
// grant with one requester across several accesses (read-modify-write).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic        CLK,
  input  logic        RST_N,
  dmem_arb_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
  localparam logic [1:0] ST_RESP   = 2'(RESP);

  // One extra bit so the compare stays correct even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          last_q,  last_d;
  logic          id_q,    id_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q,   err_d;

  logic          gnt_id;
  logic          gnt_valid;
  logic          lock_hold;
  logic          lock_sel;
  logic          addr_ok;

  assign addr_ok = ({1'b0, addr_q} < DEPTH_W);

  // ---------------------------------------------------------------------------
  // Optional grant lock
  // ---------------------------------------------------------------------------
`ifdef ARB_LOCK_EN
  logic [1:0] lock_in;
  logic       lock_act_q, lock_act_d;
  logic       lock_id_q,  lock_id_d;

  assign lock_in   = {bus.lock1, bus.lock0};
  // The lock only binds while its owner still asserts lockN; the first IDLE
  // cycle with lockN low falls through to plain round-robin.
  assign lock_hold = lock_act_q & lock_in[lock_id_q];
  assign lock_sel  = lock_id_q;

  always_comb begin
    lock_act_d = lock_act_q;
    lock_id_d  = lock_id_q;
    if (state_q == ST_IDLE) begin
      if (gnt_valid) begin
        lock_act_d = lock_in[gnt_id];
        lock_id_d  = gnt_id;
      end else if (!lock_hold) begin
        lock_act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_act_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  assign lock_hold = 1'b0;
  assign lock_sel  = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req_i       ({bus.req1, bus.req0}),
    .last_i      (last_q),
    .lock_hold_i (lock_hold),
    .lock_id_i   (lock_sel),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (gnt_valid) begin
          state_d = ST_ACCESS;
          id_d    = gnt_id;
          we_d    = gnt_id ? bus.we1    : bus.we0;
          addr_d  = gnt_id ? bus.addr1  : bus.addr0;
          wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
          // Fairness history is frozen while a lock forces the grant.
          if (!lock_hold) begin
            last_d = gnt_id;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        err_d   = ~addr_ok;
        rdata_d = (addr_ok && !we_q) ? bus.mem_rdata : '0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decode from registered state only, so reset clears them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    bus.rdata0    = '0;
    bus.rdata1    = '0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    if (state_q == ST_ACCESS) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      // Out-of-range accesses never strobe the memory.
      if (addr_ok) begin
        bus.mem_read  = ~we_q;
        bus.mem_write = we_q;
      end
    end

    if (state_q == ST_RESP) begin
      if (id_q) begin
        bus.ack1   = 1'b1;
        bus.rdata1 = rdata_q;
        bus.err1   = err_q;
      end else begin
        bus.ack0   = 1'b1;
        bus.rdata0 = rdata_q;
        bus.err0   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 32 x 8 memory model. Stimulus pushes
// the expected response of each access onto a scoreboard queue; an independent
// monitor pops and compares on every ack. Define ARB_LOCK_EN to add the lock
// scenario.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    logic       id;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arb_if bus ();

  dmem_arbiter dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  logic [7:0] mem [32];
  logic       any_write;

  // Memory model: combinational read, write on the rising edge.
  assign bus.mem_rdata = (int'(bus.mem_addr) < 32) ? mem[bus.mem_addr[4:0]] : 8'h00;
  always @(posedge CLK) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[4:0]] = bus.mem_wdata;
      any_write = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    check("strobe_excl", 32'(bus.mem_read & bus.mem_write), 0);
    if (bus.ack0 || bus.ack1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 0);
      end else begin
        e = sb_q.pop_front();
        check("ack0", 32'(bus.ack0), 32'(!e.id));
        check("ack1", 32'(bus.ack1), 32'(e.id));
        check("rdata", 32'(e.id ? bus.rdata1 : bus.rdata0), 32'(e.rdata));
        check("err", 32'(e.id ? bus.err1 : bus.err0), 32'(e.err));
        check("other_quiet", 32'(e.id ? {bus.err0, bus.rdata0} : {bus.err1, bus.rdata1}), 0);
      end
    end else begin
      check("quiet_outputs", 32'({bus.rdata0, bus.rdata1, bus.err0, bus.err1}), 0);
    end
  end

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (id) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // One uncontended access: expects the ack exactly three falling edges after
  // the request is raised (cycle N sample, N+1 strobe, N+2 ack).
  task automatic access(input logic id, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input logic exp_err);
    int k;
    sb_q.push_back('{id, exp_rdata, exp_err});
    @(posedge CLK); #1;
    drive(id, 1'b1, we, addr, wdata);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!(id ? bus.ack1 : bus.ack0) && k < 40);
    check("latency", 32'(k), 3);
    @(posedge CLK); #1;
    drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    int k;
    int acks;
    int last_k;

    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    any_write = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef ARB_LOCK_EN
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_resp", 32'({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.err0, bus.err1}), 0);
    check("rst_mem", 32'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}), 0);
    @(negedge CLK); RST_N = 1'b1;

    // 1: reset in the middle of a write access
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b1, 8'd5, 8'h3C);
    @(negedge CLK);
    check("rst_idle_wr", 32'(bus.mem_write), 0);
    @(negedge CLK);
    check("rst_access_wr", 32'(bus.mem_write), 1);
    check("rst_access_addr", 32'(bus.mem_addr), 5);
    #1 RST_N = 1'b0;
    #1;
    check("rst_async_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
    check("rst_async_ack", 32'({bus.ack0, bus.ack1}), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK); RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // 2: write then read back through requester 0
    access(1'b0, 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0);
    check("mem3_written", 32'(mem[3]), 32'hA5);
    access(1'b0, 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0);

    // 4: out-of-range write from requester 1
    any_write = 1'b0;
    access(1'b1, 1'b1, 8'd40, 8'h77, 8'h00, 1'b1);
    check("oor_no_write", 32'(any_write), 0);
    check("mem8_kept", 32'(mem[8]), 32'h08);
    // Last in-range word still works
    access(1'b1, 1'b0, 8'd31, 8'h00, 8'h1F, 1'b0);

    // 5: read timing, addr 7
    sb_q.push_back('{1'b0, 8'h07, 1'b0});
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd7, 8'h00);
    @(negedge CLK);
    check("t_n_read", 32'(bus.mem_read), 0);
    @(negedge CLK);
    check("t_n1_read", 32'(bus.mem_read), 1);
    check("t_n1_addr", 32'(bus.mem_addr), 7);
    @(negedge CLK);
    check("t_n2_read", 32'(bus.mem_read), 0);
    check("t_n2_ack", 32'(bus.ack0), 1);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    check("t_n3_rdata", 32'(bus.rdata0), 0);
    check("t_n3_ack", 32'(bus.ack0), 0);
    check("t_n3_addr", 32'(bus.mem_addr), 0);

    // 3: tie after reset, both held: grants 0,1,0,1 three cycles apart
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    sb_q.push_back('{1'b0, 8'hA5, 1'b0});
    sb_q.push_back('{1'b1, 8'h0A, 1'b0});
    sb_q.push_back('{1'b0, 8'hA5, 1'b0});
    sb_q.push_back('{1'b1, 8'h0A, 1'b0});
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd3, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd10, 8'h00);
    k = 0; acks = 0; last_k = 0;
    while (acks < 4 && k < 60) begin
      @(negedge CLK);
      k++;
      if (bus.ack0 || bus.ack1) begin
        acks++;
        if (acks > 1) check("tie_gap", 32'(k - last_k), 3);
        last_k = k;
      end
    end
    check("tie_acks", 32'(acks), 4);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge CLK);

`ifdef ARB_LOCK_EN
    // 6: locked requester 0 takes three accesses while requester 1 waits
    sb_q.push_back('{1'b0, 8'h01, 1'b0});
    sb_q.push_back('{1'b0, 8'h02, 1'b0});
    sb_q.push_back('{1'b0, 8'h04, 1'b0});
    sb_q.push_back('{1'b1, 8'h06, 1'b0});
    @(posedge CLK); #1;
    bus.lock0 = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'd1, 8'h00);
    @(posedge CLK); #1;
    drive(1'b1, 1'b1, 1'b0, 8'd6, 8'h00);
    for (int n = 0; n < 3; n++) begin
      k = 0;
      while (!bus.ack0 && k < 40) begin
        @(negedge CLK);
        k++;
      end
      check("lock_ack0_seen", 32'(bus.ack0), 1);
      @(posedge CLK); #1;
      if (n == 0) bus.addr0 = 8'd2;
      if (n == 1) bus.addr0 = 8'd4;
      if (n == 2) begin
        bus.lock0 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    k = 0;
    while (!bus.ack1 && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("lock_ack1_seen", 32'(bus.ack1), 1);
    @(posedge CLK); #1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

    // Drain the scoreboard
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    repeat (2) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
